// File: rtl/rx_line_buffer.sv
// Line-assembly buffer: collects received bytes, applies backspace editing and releases whole
// lines on the terminator. Optional echo of buffer-changing bytes via `define LINEBUF_ECHO_EN.
module rx_line_buffer #(
    parameter int         DEPTH     = 32,
    parameter logic [7:0] LINE_TERM = 8'h0D
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       dout_last,
    input  logic       dout_ready,
    output logic       line_ready,
    output logic       overflow
`ifdef LINEBUF_ECHO_EN
    ,
    output logic [7:0] echo_byte,
    output logic       echo_valid
`endif
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PW     = ADDR_W + 1;

    typedef enum logic {ACCEPT, DISCARD} state_t;

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_wr_ptr, r_cm_ptr, r_rd_ptr, r_line_cnt;
    logic [8:0]      r_mem [DEPTH];
    logic            r_overflow;

    logic            w_is_term, w_is_bs, w_partial, w_full;
    logic            w_store, w_commit, w_bksp, w_drop;
    logic            w_xfer, w_rd_last;
    logic [PW-1:0]   w_used, w_wr_prev;
    logic [8:0]      w_head;

    assign w_is_term = (din == LINE_TERM);
    assign w_is_bs   = (din == 8'h08) || (din == 8'h7F);
    assign w_partial = (r_wr_ptr != r_cm_ptr);
    assign w_used    = r_wr_ptr - r_rd_ptr;
    assign w_full    = (w_used == PW'(DEPTH));
    assign w_wr_prev = r_wr_ptr - 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_store     = 1'b0;
        w_commit    = 1'b0;
        w_bksp      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ACCEPT: begin
                if (din_valid) begin
                    if (w_is_term) begin
                        w_commit = w_partial;
                    end else if (w_is_bs) begin
                        w_bksp = w_partial;
                    end else if (w_full) begin
                        w_drop      = 1'b1;
                        w_state_nxt = DISCARD;
                    end else begin
                        w_store = 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (din_valid && w_is_term) w_state_nxt = ACCEPT;
            end
            default: w_state_nxt = ACCEPT;
        endcase
    end

    // Head entry is masked while invalid so outputs read as zero after reset.
    assign w_head     = r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign dout_valid = (r_rd_ptr != r_cm_ptr);
    assign dout       = dout_valid ? w_head[7:0] : 8'h00;
    assign dout_last  = dout_valid & w_head[8];
    assign w_xfer     = dout_valid & dout_ready;
    assign w_rd_last  = w_xfer & w_head[8];
    assign line_ready = (r_line_cnt != '0);
    assign overflow   = r_overflow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ACCEPT;
            r_wr_ptr   <= '0;
            r_cm_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_line_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_overflow <= w_drop;
            if (w_store)     r_wr_ptr <= r_wr_ptr + 1'b1;
            else if (w_bksp) r_wr_ptr <= w_wr_prev;
            else if (w_drop) r_wr_ptr <= r_cm_ptr;
            if (w_commit) r_cm_ptr <= r_wr_ptr;
            if (w_xfer)   r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_commit, w_rd_last})
                2'b10:   r_line_cnt <= r_line_cnt + 1'b1;
                2'b01:   r_line_cnt <= r_line_cnt - 1'b1;
                default: r_line_cnt <= r_line_cnt;
            endcase
        end
    end

    // Storage is not reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_store)  r_mem[r_wr_ptr[ADDR_W-1:0]] <= {1'b0, din};
        if (w_commit) r_mem[w_wr_prev[ADDR_W-1:0]][8] <= 1'b1;
    end

`ifdef LINEBUF_ECHO_EN
    logic [7:0] r_echo_byte;
    logic       r_echo_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_echo_byte  <= 8'h00;
            r_echo_valid <= 1'b0;
        end else begin
            r_echo_valid <= w_store | w_commit | w_bksp;
            if (w_store | w_commit | w_bksp) r_echo_byte <= din;
        end
    end

    assign echo_byte  = r_echo_byte;
    assign echo_valid = r_echo_valid;
`endif
endmodule

// File: tb/tb_rx_line_buffer.sv
// Self-checking bench for rx_line_buffer: directed scenarios plus random traffic against a
// queue-based line model (committed bytes, partial line, discard flag).
module tb_rx_line_buffer;
    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       din_valid;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_last;
    logic       dout_ready;
    logic       line_ready;
    logic       overflow;
`ifdef LINEBUF_ECHO_EN
    logic [7:0] echo_byte;
    logic       echo_valid;
`endif

    rx_line_buffer #(.DEPTH(DEPTH), .LINE_TERM(8'h0D)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_last  (dout_last),
        .dout_ready (dout_ready),
        .line_ready (line_ready),
        .overflow   (overflow)
`ifdef LINEBUF_ECHO_EN
        ,
        .echo_byte  (echo_byte),
        .echo_valid (echo_valid)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: committed bytes {last,byte}, current partial line, discard mode.
    logic [8:0] q_out[$];
    logic [7:0] q_part[$];
    bit         discard;
    bit         exp_ovf;
    bit         exp_echo_v;
    logic [7:0] exp_echo_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs();
        int  lines;
        bit  v;
        lines = 0;
        foreach (q_out[i]) if (q_out[i][8]) lines++;
        v = (q_out.size() != 0);
        chk("dout_valid", dout_valid, v);
        if (v) begin
            chk("dout", dout, q_out[0][7:0]);
            chk("dout_last", dout_last, q_out[0][8]);
        end
        chk("line_ready", line_ready, lines != 0);
        chk("overflow", overflow, exp_ovf);
`ifdef LINEBUF_ECHO_EN
        chk("echo_valid", echo_valid, exp_echo_v);
        if (exp_echo_v) chk("echo_byte", echo_byte, exp_echo_b);
`endif
    endtask

    task automatic model_clear();
        q_out.delete();
        q_part.delete();
        discard    = 0;
        exp_ovf    = 0;
        exp_echo_v = 0;
        exp_echo_b = 8'h00;
    endtask

    // One clock: drive inputs, advance the model on pre-edge state, check after the edge.
    task automatic cyc(input bit v, input logic [7:0] d, input bit rdy);
        bit full;
        bit xfer;
        din_valid = v;
        din       = d;
        dout_ready = rdy;
        full = (q_out.size() + q_part.size()) == DEPTH;
        xfer = rdy && (q_out.size() != 0);
        exp_ovf    = 0;
        exp_echo_v = 0;
        if (xfer) void'(q_out.pop_front());
        if (v) begin
            if (discard) begin
                if (d == 8'h0D) discard = 0;
            end else if (d == 8'h0D) begin
                if (q_part.size() != 0) begin
                    foreach (q_part[i]) q_out.push_back({i == q_part.size() - 1, q_part[i]});
                    q_part.delete();
                    exp_echo_v = 1; exp_echo_b = d;
                end
            end else if (d == 8'h08 || d == 8'h7F) begin
                if (q_part.size() != 0) begin
                    void'(q_part.pop_back());
                    exp_echo_v = 1; exp_echo_b = d;
                end
            end else if (full) begin
                q_part.delete();
                discard = 1;
                exp_ovf = 1;
            end else begin
                q_part.push_back(d);
                exp_echo_v = 1; exp_echo_b = d;
            end
        end
        @(posedge clk);
        #1;
        check_outs();
    endtask

    task automatic send(input string s, input bit rdy);
        for (int i = 0; i < s.len(); i++) cyc(1, s[i], rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(0, 8'h00, rdy);
    endtask

    task automatic do_reset();
        reset = 1;
        din_valid = 0;
        dout_ready = 0;
        #2;
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout_last", dout_last, 0);
        chk("rst_dout", dout, 0);
        chk("rst_line_ready", line_ready, 0);
        chk("rst_overflow", overflow, 0);
`ifdef LINEBUF_ECHO_EN
        chk("rst_echo_valid", echo_valid, 0);
        chk("rst_echo_byte", echo_byte, 0);
`endif
        model_clear();
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    initial begin
        reset = 1; din = 8'h00; din_valid = 0; dout_ready = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Basic line
        send("1+2", 1); cyc(1, 8'h0D, 1); idle(5, 1);
        // Backspace editing, lone editing/terminator on empty buffer
        send("12", 1); cyc(1, 8'h08, 1); send("3", 1); cyc(1, 8'h0D, 1); idle(4, 1);
        cyc(1, 8'h08, 1); cyc(1, 8'h0D, 1); cyc(1, 8'h7F, 1); idle(2, 1);
        // Overflow: 33 bytes, then dropped tail, then recovery
        for (int i = 0; i < 33; i++) cyc(1, 8'h61 + 8'(i % 26), 1);
        send("xyz", 1); cyc(1, 8'h08, 1); cyc(1, 8'h0D, 1);
        send("7", 1); cyc(1, 8'h0D, 1); idle(3, 1);
        // Hold two lines, release, then many lines across wrap
        send("A", 0); cyc(1, 8'h0D, 0); send("BC", 0); cyc(1, 8'h0D, 0); idle(3, 0);
        idle(5, 1);
        for (int l = 0; l < 20; l++) begin
            for (int b = 0; b < 3; b++) cyc(1, 8'h30 + 8'($urandom_range(0, 74)), 1);
            cyc(1, 8'h0D, 1);
        end
        idle(3, 1);
        // Exactly DEPTH bytes plus terminator commits
        for (int i = 0; i < DEPTH; i++) cyc(1, 8'h41 + 8'(i % 26), 0);
        cyc(1, 8'h0D, 0); idle(2, 0); idle(DEPTH + 2, 1);
        // Reset mid partial line and with a committed line pending
        send("12", 1); do_reset(); send("9", 1); cyc(1, 8'h0D, 1); idle(3, 1);
        send("45", 0); cyc(1, 8'h0D, 0); send("6", 0); do_reset();
        send("9", 1); cyc(1, 8'h0D, 1); idle(3, 1);
        // Echo sequence (echo checks active only when the feature is built)
        send("5", 1); cyc(1, 8'h08, 1); cyc(1, 8'h08, 1); cyc(1, 8'h0D, 1); idle(2, 1);

        // Random traffic with alternating backpressure phases
        for (int n = 0; n < 4000; n++) begin
            bit         v;
            bit         rdy;
            int         r;
            logic [7:0] d;
            v = ($urandom % 4) != 0;
            r = $urandom % 24;
            if (r < 2)       d = 8'h0D;
            else if (r == 2) d = 8'h08;
            else if (r == 3) d = 8'h7F;
            else             d = 8'h20 + 8'($urandom % 95);
            if (d == 8'h7F && r != 3) d = 8'h41;
            rdy = ((n / 200) % 2 == 0) ? (($urandom % 10) < 7) : (($urandom % 10) < 1);
            cyc(v, d, rdy);
        end
        idle(DEPTH + 4, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
